// File: rtl/wb_trace_pkg.sv
// Shared types and default widths for the writeback trace recorder.
package wb_trace_pkg;

    localparam int REG_WIDTH_DEF   = 32;
    localparam int IDX_WIDTH_DEF   = 5;
    localparam int DEPTH_DEF       = 64;
    localparam int CYCLE_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [CYCLE_WIDTH_DEF-1:0] cycle;
        logic [IDX_WIDTH_DEF-1:0]   idx;
        logic [REG_WIDTH_DEF-1:0]   val;
    } trace_entry_t;

    function automatic int entryWidth(input int cycleW, input int idxW, input int regW);
        return cycleW + idxW + regW;
    endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Writeback snoop port plus valid/ready drain port of the trace recorder.
interface wb_trace_buffer_if #(
    parameter int REG_WIDTH   = 32,
    parameter int IDX_WIDTH   = 5,
    parameter int CYCLE_WIDTH = 32
) ();
    logic                   wb_en;
    logic [IDX_WIDTH-1:0]   wb_idx;
    logic [REG_WIDTH-1:0]   wb_val;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [CYCLE_WIDTH-1:0] rd_cycle;
    logic [IDX_WIDTH-1:0]   rd_idx;
    logic [REG_WIDTH-1:0]   rd_val;

    modport master (
        output wb_en, wb_idx, wb_val, rd_ready,
        input  rd_valid, rd_cycle, rd_idx, rd_val
    );

    modport slave (
        input  wb_en, wb_idx, wb_val, rd_ready,
        output rd_valid, rd_cycle, rd_idx, rd_val
    );
endinterface

// File: rtl/wb_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
module wb_trace_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 69
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wAddr,
    input  logic [WIDTH-1:0]         wData,
    input  logic [$clog2(DEPTH)-1:0] rAddr,
    output logic [WIDTH-1:0]         rData
);
    logic [WIDTH-1:0] mem_r [DEPTH];

    // storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wAddr] <= wData;
        end
    end

    // registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rData <= {WIDTH{1'b0}};
        end else begin
            rData <= mem_r[rAddr];
        end
    end
endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace recorder: cycle-stamped circular buffer drained oldest-first.
// Optional macro WB_TRACE_FILTER_X0_EN drops writes to x0 instead of recording them.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int REG_WIDTH   = REG_WIDTH_DEF,
    parameter int IDX_WIDTH   = IDX_WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int CYCLE_WIDTH = CYCLE_WIDTH_DEF,
    parameter int WRAP_MODE   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       stop,
    wb_trace_buffer_if.slave           bus,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = entryWidth(CYCLE_WIDTH, IDX_WIDTH, REG_WIDTH);
    localparam bit WRAP_EN = (WRAP_MODE != 32'sd0);

    state_t                 state_r, stateNext_s;
    logic [PW-1:0]          wrPtr_r, rdPtr_r;
    logic [CW-1:0]          count_r;
    logic [CYCLE_WIDTH-1:0] cycle_r;
    logic                   overflow_r;
    logic                   fresh_r;
    logic                   accept_s, full_s, recWrite_s, ramWe_s, pop_s, rdValid_s;
    logic [EW-1:0]          rdData_s;

`ifdef WB_TRACE_FILTER_X0_EN
    assign accept_s = bus.wb_en & (bus.wb_idx != {IDX_WIDTH{1'b0}});
`else
    assign accept_s = bus.wb_en;
`endif

    assign full_s     = (count_r == CW'(DEPTH));
    assign recWrite_s = (state_r == REC) & accept_s;
    assign ramWe_s    = recWrite_s & (~full_s | WRAP_EN);
    // fresh_r marks that the registered RAM output reflects the entry at rdPtr_r
    assign rdValid_s  = (state_r == DRAIN) & (count_r != {CW{1'b0}}) & fresh_r;
    assign pop_s      = rdValid_s & bus.rd_ready;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // next-state decode
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE:    if (arm) stateNext_s = REC; else stateNext_s = IDLE;
            REC:     if (stop) stateNext_s = DRAIN; else stateNext_s = REC;
            DRAIN:   if (count_r == {CW{1'b0}}) stateNext_s = IDLE; else stateNext_s = DRAIN;
            default: stateNext_s = IDLE;
        endcase
    end

    // pointers, occupancy, sticky overflow and cycle stamp
    always_ff @(posedge clk) begin
        if (rst || (state_r == IDLE && arm)) begin
            wrPtr_r    <= {PW{1'b0}};
            rdPtr_r    <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            cycle_r    <= {CYCLE_WIDTH{1'b0}};
            overflow_r <= 1'b0;
            fresh_r    <= 1'b0;
        end else begin
            if (ramWe_s) wrPtr_r <= wrPtr_r + PW'(1);
            if ((ramWe_s & full_s) | pop_s) rdPtr_r <= rdPtr_r + PW'(1);
            if (ramWe_s & ~full_s) begin
                count_r <= count_r + CW'(1);
            end else if (pop_s) begin
                count_r <= count_r - CW'(1);
            end
            if (recWrite_s & full_s) overflow_r <= 1'b1;
            if (state_r == REC) cycle_r <= cycle_r + CYCLE_WIDTH'(1);
            fresh_r <= ~(ramWe_s | pop_s);
        end
    end

    wb_trace_ram #(.DEPTH(DEPTH), .WIDTH(EW)) uRam (
        .clk   (clk),
        .rst   (rst),
        .we    (ramWe_s),
        .wAddr (wrPtr_r),
        .wData ({cycle_r, bus.wb_idx, bus.wb_val}),
        .rAddr (rdPtr_r),
        .rData (rdData_s)
    );

    assign bus.rd_valid = rdValid_s;
    assign bus.rd_cycle = rdValid_s ? rdData_s[EW-1 -: CYCLE_WIDTH] : {CYCLE_WIDTH{1'b0}};
    assign bus.rd_idx   = rdValid_s ? rdData_s[REG_WIDTH +: IDX_WIDTH] : {IDX_WIDTH{1'b0}};
    assign bus.rd_val   = rdValid_s ? rdData_s[REG_WIDTH-1:0] : {REG_WIDTH{1'b0}};
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign busy         = (state_r != IDLE);
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench: three instances (DEPTH 64 wrap, DEPTH 4 wrap, DEPTH 4 stall).
module tb_wb_trace_buffer;
    logic clk = 1'b0;
    logic rst;
    logic armA, stopA, armW, stopW, armS, stopS;
    logic wbEn, rdReady;
    logic [4:0]  wbIdx;
    logic [31:0] wbVal;
    logic [6:0]  countA;
    logic [2:0]  countW, countS;
    logic ovA, ovW, ovS, busyA, busyW, busyS;
    int sel;
    int nChecks = 0;
    int nFails  = 0;

    logic        obsValid, obsOv, obsBusy;
    logic [7:0]  obsCount;
    logic [31:0] obsCycle, obsVal;
    logic [4:0]  obsIdx;

    always #5 clk = ~clk;

    wb_trace_buffer_if #(.REG_WIDTH(32), .IDX_WIDTH(5), .CYCLE_WIDTH(32)) busA ();
    wb_trace_buffer_if #(.REG_WIDTH(32), .IDX_WIDTH(5), .CYCLE_WIDTH(32)) busW ();
    wb_trace_buffer_if #(.REG_WIDTH(32), .IDX_WIDTH(5), .CYCLE_WIDTH(32)) busS ();

    assign busA.wb_en = wbEn;  assign busA.wb_idx = wbIdx;  assign busA.wb_val = wbVal;  assign busA.rd_ready = rdReady;
    assign busW.wb_en = wbEn;  assign busW.wb_idx = wbIdx;  assign busW.wb_val = wbVal;  assign busW.rd_ready = rdReady;
    assign busS.wb_en = wbEn;  assign busS.wb_idx = wbIdx;  assign busS.wb_val = wbVal;  assign busS.rd_ready = rdReady;

    wb_trace_buffer #(.REG_WIDTH(32), .IDX_WIDTH(5), .DEPTH(64), .CYCLE_WIDTH(32), .WRAP_MODE(1)) dutA (
        .clk(clk), .rst(rst), .arm(armA), .stop(stopA), .bus(busA.slave),
        .count(countA), .overflow(ovA), .busy(busyA));
    wb_trace_buffer #(.REG_WIDTH(32), .IDX_WIDTH(5), .DEPTH(4), .CYCLE_WIDTH(32), .WRAP_MODE(1)) dutW (
        .clk(clk), .rst(rst), .arm(armW), .stop(stopW), .bus(busW.slave),
        .count(countW), .overflow(ovW), .busy(busyW));
    wb_trace_buffer #(.REG_WIDTH(32), .IDX_WIDTH(5), .DEPTH(4), .CYCLE_WIDTH(32), .WRAP_MODE(0)) dutS (
        .clk(clk), .rst(rst), .arm(armS), .stop(stopS), .bus(busS.slave),
        .count(countS), .overflow(ovS), .busy(busyS));

    always_comb begin
        case (sel)
            0: begin
                obsValid = busA.rd_valid; obsCycle = busA.rd_cycle; obsIdx = busA.rd_idx; obsVal = busA.rd_val;
                obsCount = 8'(countA); obsOv = ovA; obsBusy = busyA;
            end
            1: begin
                obsValid = busW.rd_valid; obsCycle = busW.rd_cycle; obsIdx = busW.rd_idx; obsVal = busW.rd_val;
                obsCount = 8'(countW); obsOv = ovW; obsBusy = busyW;
            end
            default: begin
                obsValid = busS.rd_valid; obsCycle = busS.rd_cycle; obsIdx = busS.rd_idx; obsVal = busS.rd_val;
                obsCount = 8'(countS); obsOv = ovS; obsBusy = busyS;
            end
        endcase
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for rd_valid, checks the entry, then lets the next edge pop it.
    task automatic expectEntry(input string tag, input logic [31:0] c, input logic [4:0] i, input logic [31:0] v);
        int n;
        n = 0;
        while (!obsValid && n < 10) begin
            step();
            n++;
        end
        if (!obsValid) begin
            check({tag, "_valid"}, 64'(obsValid), 64'd1);
        end else begin
            check({tag, "_cycle"}, 64'(obsCycle), 64'(c));
            check({tag, "_idx"}, 64'(obsIdx), 64'(i));
            check({tag, "_val"}, 64'(obsVal), 64'(v));
            step();
        end
    endtask

    task automatic wr(input logic [4:0] i, input logic [31:0] v);
        wbEn = 1'b1; wbIdx = i; wbVal = v;
    endtask

    initial begin
        rst = 1'b1; sel = 0;
        armA = 1'b0; stopA = 1'b0; armW = 1'b0; stopW = 1'b0; armS = 1'b0; stopS = 1'b0;
        wbEn = 1'b0; wbIdx = 5'd0; wbVal = 32'd0; rdReady = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        check("reset_count", 64'(obsCount), 64'd0);
        check("reset_overflow", 64'(obsOv), 64'd0);
        check("reset_busy", 64'(obsBusy), 64'd0);
        check("reset_valid", 64'(obsValid), 64'd0);
        check("reset_val", 64'(obsVal), 64'd0);

        // basic trace: writes stamped 2, 4, 5
        armA = 1'b1; step();
        armA = 1'b0; check("rec_busy", 64'(obsBusy), 64'd1); step();
        step();
        wr(5'd1, 32'd5); step();
        wbEn = 1'b0; step();
        wr(5'd2, 32'd7); step();
        wr(5'd3, 32'd12); step();
        wbEn = 1'b0; stopA = 1'b1; step();
        stopA = 1'b0;
        check("basic_count", 64'(obsCount), 64'd3);
        rdReady = 1'b1;
        expectEntry("basic_e0", 32'd2, 5'd1, 32'd5);
        expectEntry("basic_e1", 32'd4, 5'd2, 32'd7);
        expectEntry("basic_e2", 32'd5, 5'd3, 32'd12);
        step(); step(); step();
        check("basic_idle", 64'(obsBusy), 64'd0);
        check("basic_overflow", 64'(obsOv), 64'd0);

        // DEPTH 4 wrap: oldest two lost
        sel = 1; rdReady = 1'b0;
        armW = 1'b1; step();
        armW = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            wr(5'(k), 32'(k)); step();
        end
        wbEn = 1'b0; stopW = 1'b1; step();
        stopW = 1'b0;
        check("wrap_count", 64'(obsCount), 64'd4);
        check("wrap_overflow", 64'(obsOv), 64'd1);
        rdReady = 1'b1;
        for (int k = 3; k <= 6; k++) expectEntry("wrap_e", 32'(k - 1), 5'(k), 32'(k));
        step(); step(); step();
        check("wrap_idle", 64'(obsBusy), 64'd0);

        // DEPTH 4 stall: newest two dropped; stalled drain ignores writes
        sel = 2; rdReady = 1'b0;
        armS = 1'b1; step();
        armS = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            wr(5'(k), 32'(k)); step();
            if (k == 4) check("stall_peak", 64'(obsCount), 64'd4);
        end
        wbEn = 1'b0; stopS = 1'b1; step();
        stopS = 1'b0;
        check("stall_overflow", 64'(obsOv), 64'd1);
        for (int k = 0; k < 3; k++) begin
            wr(5'd9, 32'hDEAD);
            check("hold_valid", 64'(obsValid), 64'd1);
            check("hold_val", 64'(obsVal), 64'd1);
            check("hold_cycle", 64'(obsCycle), 64'd0);
            check("hold_count", 64'(obsCount), 64'd4);
            step();
        end
        wbEn = 1'b0; rdReady = 1'b1;
        for (int k = 1; k <= 4; k++) expectEntry("stall_e", 32'(k - 1), 5'(k), 32'(k));
        step(); step(); step();
        check("stall_idle", 64'(obsBusy), 64'd0);

        // stop together with a write
        sel = 0; rdReady = 1'b0;
        armA = 1'b1; step();
        armA = 1'b0; wr(5'd1, 32'd11); step();
        wr(5'd4, 32'd9); stopA = 1'b1; step();
        wbEn = 1'b0; stopA = 1'b0; rdReady = 1'b1;
        expectEntry("stopwr_e0", 32'd0, 5'd1, 32'd11);
        expectEntry("stopwr_e1", 32'd1, 5'd4, 32'd9);
        step(); step(); step();
        check("stopwr_idle", 64'(obsBusy), 64'd0);
        check("stopwr_count", 64'(obsCount), 64'd0);

        // x0 write then x5
        rdReady = 1'b0;
        armA = 1'b1; step();
        armA = 1'b0; wr(5'd0, 32'hFF); step();
        wr(5'd5, 32'd1); step();
        wbEn = 1'b0; stopA = 1'b1; step();
        stopA = 1'b0; step();
`ifdef WB_TRACE_FILTER_X0_EN
        check("x0_count", 64'(obsCount), 64'd1);
        rdReady = 1'b1;
        expectEntry("x0_e0", 32'd1, 5'd5, 32'd1);
`else
        check("x0_count", 64'(obsCount), 64'd2);
        rdReady = 1'b1;
        expectEntry("x0_e0", 32'd0, 5'd0, 32'hFF);
        expectEntry("x0_e1", 32'd1, 5'd5, 32'd1);
`endif
        check("x0_overflow", 64'(obsOv), 64'd0);
        step(); step(); step();

        // reset in the middle of a drain
        rdReady = 1'b0;
        armA = 1'b1; step();
        armA = 1'b0; wr(5'd1, 32'd1); step();
        wr(5'd2, 32'd2); step();
        wbEn = 1'b0; stopA = 1'b1; step();
        stopA = 1'b0; step();
        check("middrain_count", 64'(obsCount), 64'd2);
        check("middrain_valid", 64'(obsValid), 64'd1);
        rst = 1'b1; step();
        check("rst_valid", 64'(obsValid), 64'd0);
        check("rst_count", 64'(obsCount), 64'd0);
        check("rst_busy", 64'(obsBusy), 64'd0);
        rst = 1'b0; step();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
